// File: rtl/solver_dispatch.sv
// Dynamic row dispatcher between NUM_SOLVERS pattern solvers and one frame-buffer write port.
// Define SOLVER_STATS_EN to add per-channel row counts and a grant-stall counter.
module solver_dispatch #(
    parameter int NUM_SOLVERS = 4,
    parameter int NUM_COLUMNS = 640,
    parameter int NUM_ROWS    = 480,
    parameter int COORD_W     = 27,
    parameter int PIX_W       = 4,
    parameter int ROW_W       = 10,
    parameter int ADDR_W      = 19
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic signed [COORD_W-1:0]        min_y,
    input  logic signed [COORD_W-1:0]        dy,
    output logic [NUM_SOLVERS-1:0]           job_valid,
    input  logic [NUM_SOLVERS-1:0]           job_ready,
    output logic [ROW_W-1:0]                 job_row,
    output logic signed [COORD_W-1:0]        job_y,
    input  logic [NUM_SOLVERS-1:0]           res_valid,
    output logic [NUM_SOLVERS-1:0]           res_ready,
    input  logic [NUM_SOLVERS*PIX_W-1:0]     res_data,
    output logic                             fb_wr_en,
    output logic [ADDR_W-1:0]                fb_wr_addr,
    output logic [PIX_W-1:0]                 fb_wr_data,
    output logic                             busy,
    output logic                             done,
    output logic [31:0]                      solve_time,
`ifdef SOLVER_STATS_EN
    input  logic [4:0]                       stat_sel,
    output logic [ROW_W-1:0]                 stat_rows,
    output logic [31:0]                      stat_stall,
`endif
    output logic                             proto_err
);

    localparam int N     = NUM_SOLVERS;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                    state;
    logic [N-1:0]              active;
    logic [ADDR_W-1:0]         base [N];
    logic [COL_W-1:0]          col  [N];
    logic [ROW_W:0]            row_cnt;
    logic signed [COORD_W-1:0] next_y;
    logic signed [COORD_W-1:0] dy_q;
    logic [ADDR_W-1:0]         next_base;
    logic [PTR_W-1:0]          job_ptr;
    logic [PTR_W-1:0]          res_ptr;

    logic [N-1:0]     job_req, res_req, job_gnt, res_gnt;
    logic             job_hit, res_hit;
    logic [PTR_W-1:0] job_idx, res_idx, ji, ri;
    logic             rows_left, launch, running, res_last;

    assign rows_left = row_cnt < (ROW_W+1)'(NUM_ROWS);
    assign running   = (state == RUN) || (state == DRAIN);
    assign launch    = start && ((state == IDLE) || (state == DONE));
    assign busy      = running;
    assign done      = (state == DONE);
    assign job_row   = row_cnt[ROW_W-1:0];
    assign job_y     = next_y;
    assign job_valid = job_gnt;
    assign res_ready = res_gnt;
    assign res_last  = res_hit && (col[res_idx] == COL_W'(NUM_COLUMNS - 1));

    // Both searches start one past the last winner, giving round-robin order.
    always_comb begin
        job_req = (state == RUN && rows_left) ? (~active & job_ready) : '0;
        res_req = active & res_valid;
        job_hit = 1'b0;
        res_hit = 1'b0;
        job_idx = '0;
        res_idx = '0;
        ji      = '0;
        ri      = '0;
        job_gnt = '0;
        res_gnt = '0;
        for (int k = 1; k <= N; k++) begin
            ji = PTR_W'((int'(job_ptr) + k) % N);
            ri = PTR_W'((int'(res_ptr) + k) % N);
            if (!job_hit && job_req[ji]) begin
                job_hit = 1'b1;
                job_idx = ji;
            end
            if (!res_hit && res_req[ri]) begin
                res_hit = 1'b1;
                res_idx = ri;
            end
        end
        if (job_hit) job_gnt[job_idx] = 1'b1;
        if (res_hit) res_gnt[res_idx] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            active     <= '0;
            row_cnt    <= '0;
            next_y     <= '0;
            dy_q       <= '0;
            next_base  <= '0;
            job_ptr    <= LAST;
            res_ptr    <= LAST;
            fb_wr_en   <= 1'b0;
            fb_wr_addr <= '0;
            fb_wr_data <= '0;
            solve_time <= '0;
            proto_err  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                base[i] <= '0;
                col[i]  <= '0;
            end
        end else begin
            fb_wr_en <= res_hit;
            if (res_hit) begin
                fb_wr_addr <= base[res_idx] + ADDR_W'(col[res_idx]);
                fb_wr_data <= res_data[int'(res_idx)*PIX_W +: PIX_W];
                res_ptr    <= res_idx;
                col[res_idx] <= col[res_idx] + COL_W'(1);
                if (res_last) active[res_idx] <= 1'b0;
            end
            if (job_hit) begin
                active[job_idx] <= 1'b1;
                base[job_idx]   <= next_base;
                col[job_idx]    <= '0;
                row_cnt         <= row_cnt + (ROW_W+1)'(1);
                next_y          <= next_y + dy_q;
                next_base       <= next_base + ADDR_W'(NUM_COLUMNS);
                job_ptr         <= job_idx;
            end
            if (running && |(res_valid & ~active)) proto_err <= 1'b1;
            if (running && solve_time != '1) solve_time <= solve_time + 32'd1;
            unique case (state)
                IDLE, DONE: begin
                    // A fresh frame also restarts both arbiters at channel 0.
                    if (launch) begin
                        state      <= RUN;
                        dy_q       <= dy;
                        next_y     <= min_y;
                        row_cnt    <= '0;
                        next_base  <= '0;
                        solve_time <= '0;
                        proto_err  <= 1'b0;
                        job_ptr    <= LAST;
                        res_ptr    <= LAST;
                    end
                end
                RUN: begin
                    if (!rows_left) state <= DRAIN;
                end
                DRAIN: begin
                    if (active == '0 && !fb_wr_en) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SOLVER_STATS_EN
    logic [ROW_W-1:0] rows_done [N];
    logic [31:0]      stall_q;

    assign stat_stall = stall_q;
    assign stat_rows  = (int'(stat_sel) < N) ? rows_done[PTR_W'(stat_sel)] : '0;

    always_ff @(posedge clock) begin
        if (reset || launch) begin
            stall_q <= '0;
            for (int i = 0; i < N; i++) rows_done[i] <= '0;
        end else begin
            if (|(res_req & ~res_gnt) && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (res_last) rows_done[res_idx] <= rows_done[res_idx] + ROW_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_solver_dispatch.sv
// Directed bench for solver_dispatch: 4 channels, 8x4 frame, behavioural solver model.
// Build with SOLVER_STATS_EN defined to also check the statistics ports.
module tb_solver_dispatch;

    localparam int NS = 4;
    localparam int NC = 8;
    localparam int NR = 4;
    localparam int CW = 27;
    localparam int PW = 4;
    localparam int RW = 10;
    localparam int AW = 19;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic signed [CW-1:0] min_y = '0;
    logic signed [CW-1:0] dy = '0;
    logic [NS-1:0]        job_valid;
    logic [NS-1:0]        job_ready = '0;
    logic [RW-1:0]        job_row;
    logic signed [CW-1:0] job_y;
    logic [NS-1:0]        res_valid = '0;
    logic [NS-1:0]        res_ready;
    logic [NS*PW-1:0]     res_data = '0;
    logic                 fb_wr_en;
    logic [AW-1:0]        fb_wr_addr;
    logic [PW-1:0]        fb_wr_data;
    logic                 busy;
    logic                 done;
    logic [31:0]          solve_time;
    logic                 proto_err;
`ifdef SOLVER_STATS_EN
    logic [4:0]           stat_sel = '0;
    logic [RW-1:0]        stat_rows;
    logic [31:0]          stat_stall;
`endif

    solver_dispatch #(
        .NUM_SOLVERS(NS), .NUM_COLUMNS(NC), .NUM_ROWS(NR),
        .COORD_W(CW), .PIX_W(PW), .ROW_W(RW), .ADDR_W(AW)
    ) dut (
        .clock(clk), .reset(reset), .start(start),
        .min_y(min_y), .dy(dy),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_row(job_row), .job_y(job_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
        .busy(busy), .done(done), .solve_time(solve_time),
`ifdef SOLVER_STATS_EN
        .stat_sel(stat_sel), .stat_rows(stat_rows), .stat_stall(stat_stall),
`endif
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [NS-1:0]        ready_mask = '0;
    logic [NS-1:0]        vmask = '0;
    logic [NS-1:0]        force_v = '0;
    logic [NS-1:0]        ch_job = '0;
    int                   ch_row [NS];
    int                   ch_col [NS];
    int                   disp_cnt [NS];
    int                   exp_row;
    logic signed [CW-1:0] exp_y;
    logic signed [CW-1:0] dy_m;
    bit                   exp_en = 0;
    int                   exp_addr, exp_data;
    int                   wr_cnt [NR*NC];
    int                   wr_seq;
    bit                   seq_check = 0;
    int                   busy_cycles;
    int                   grant_log [$];
    logic [31:0]          st_hold;

    function automatic int pix(input int a);
        return (a * 7 + 3) & 15;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] ev);
        tests++;
        assert (obs === ev) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, ev);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NS; i++) begin
            job_ready[i] = ready_mask[i] && !ch_job[i];
            res_valid[i] = (ch_job[i] && vmask[i]) || force_v[i];
            res_data[i*PW +: PW] = PW'(pix(ch_row[i] * NC + ch_col[i]));
        end
    endtask

    task automatic cycle();
        logic [NS-1:0] jf, rf, elig;
        int ji, ri;
        @(negedge clk);
        if (busy) busy_cycles++;
        chk("fb_wr_en", fb_wr_en, exp_en);
        if (exp_en) begin
            chk("fb_wr_addr", fb_wr_addr, exp_addr);
            chk("fb_wr_data", fb_wr_data, exp_data);
            if (fb_wr_addr < NR*NC) wr_cnt[fb_wr_addr]++;
            if (seq_check) chk("seq_addr", fb_wr_addr, wr_seq);
            wr_seq++;
        end
        elig = res_valid & ch_job;
        chk("grant_legal", res_ready & ~elig, 0);
        chk("grant_onehot", $onehot0(res_ready), 1);
        chk("grant_some", |res_ready, |elig);
        jf = job_valid & job_ready;
        ji = -1;
        ri = -1;
        for (int i = 0; i < NS; i++) begin
            if (jf[i]) ji = i;
            if (res_ready[i] && res_valid[i]) ri = i;
        end
        if (job_valid != 0) begin
            chk("job_onehot", $onehot(job_valid), 1);
            chk("job_legal", job_valid & ~job_ready, 0);
            chk("job_row", job_row, exp_row);
            chk("job_y", job_y, exp_y);
        end
        rf = res_ready & res_valid;
        @(posedge clk);
        #1;
        if (reset) begin
            ch_job = '0;
            exp_en = 0;
        end else begin
            exp_en = 0;
            if (ri >= 0) begin
                exp_en   = 1;
                exp_addr = ch_row[ri] * NC + ch_col[ri];
                exp_data = pix(exp_addr);
                grant_log.push_back(ri);
                ch_col[ri]++;
                if (ch_col[ri] == NC) ch_job[ri] = 1'b0;
            end
            if (ji >= 0) begin
                ch_job[ji] = 1'b1;
                ch_row[ji] = exp_row;
                ch_col[ji] = 0;
                disp_cnt[ji]++;
                exp_row++;
                exp_y = exp_y + dy_m;
            end
        end
        drive_inputs();
    endtask

    task automatic launch(input int my, input int d);
        min_y = CW'(my);
        dy    = CW'(d);
        dy_m  = CW'(d);
        exp_row = 0;
        exp_y   = CW'(my);
        wr_seq  = 0;
        busy_cycles = 0;
        grant_log.delete();
        for (int a = 0; a < NR*NC; a++) wr_cnt[a] = 0;
        for (int i = 0; i < NS; i++) disp_cnt[i] = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (done) break;
            cycle();
        end
        chk("done_reached", done, 1);
    endtask

    task automatic frame_check(input bit perr);
        chk("solve_time", solve_time, busy_cycles);
        chk("proto_err", proto_err, perr);
        chk("rows_dispatched", exp_row, NR);
        for (int a = 0; a < NR*NC; a++) chk("write_once", wr_cnt[a], 1);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            ch_row[i] = 0;
            ch_col[i] = 0;
            disp_cnt[i] = 0;
        end
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_job_valid", job_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_fb_wr_en", fb_wr_en, 0);
        chk("rst_fb_wr_addr", fb_wr_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_solve_time", solve_time, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_job_row", job_row, 0);
        chk("rst_job_y", job_y, 0);

        // all channels ready, solvers answer every cycle
        ready_mask = 4'hF;
        vmask = 4'hF;
        drive_inputs();
        launch(-100, 5);
        chk("busy_after_start", busy, 1);
        run_to_done(500);
        frame_check(0);
        for (int i = 0; i < NS; i++) chk("spread_dispatch", disp_cnt[i], 1);
        st_hold = solve_time;
        cycle();
        cycle();
        chk("done_holds", done, 1);
        chk("solve_time_holds", solve_time, st_hold);

        // only channel 2 accepts rows
        ready_mask = 4'b0100;
        drive_inputs();
        seq_check = 1;
        launch(0, 1);
        run_to_done(500);
        frame_check(0);
        chk("ch2_rows", disp_cnt[2], NR);
        seq_check = 0;
`ifdef SOLVER_STATS_EN
        stat_sel = 5'd2;
        #1;
        chk("stat_rows_ch2", stat_rows, NR);
        stat_sel = 5'd0;
        #1;
        chk("stat_rows_ch0", stat_rows, 0);
`endif

        // fill all channels first, then release results together
        ready_mask = 4'hF;
        vmask = 4'h0;
        drive_inputs();
        launch(10, -3);
        repeat (6) cycle();
        chk("drain_busy", busy, 1);
        chk("drain_no_job", job_valid, 0);
        chk("all_busy", ch_job, 4'hF);
        vmask = 4'hF;
        drive_inputs();
        run_to_done(500);
        frame_check(0);
        for (int g = 0; g < 8; g++) chk("grant_rotation", grant_log[g], g % NS);
`ifdef SOLVER_STATS_EN
        chk("stat_stall", stat_stall, 31);
`endif

        // idle channel 3 asserts res_valid; mid-run start is ignored
        ready_mask = 4'b0001;
        force_v = 4'b1000;
        drive_inputs();
        launch(0, 1);
        repeat (5) cycle();
        chk("proto_err_set", proto_err, 1);
        chk("mid_run_busy", busy, 1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("start_ignored_perr", proto_err, 1);
        chk("start_ignored_busy", busy, 1);
        force_v = 4'b0000;
        drive_inputs();
        run_to_done(1000);
        frame_check(1);
        chk("ch0_rows", disp_cnt[0], NR);

        // reset in the middle of DRAIN
        ready_mask = 4'hF;
        vmask = 4'h0;
        drive_inputs();
        launch(5, 2);
        repeat (6) cycle();
        vmask = 4'hF;
        drive_inputs();
        repeat (3) cycle();
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_fb_wr_en", fb_wr_en, 0);
        chk("midrst_done", done, 0);
        chk("midrst_res_ready", res_ready, 0);
        chk("midrst_job_valid", job_valid, 0);
        chk("midrst_solve_time", solve_time, 0);
        launch(-1, -1);
        run_to_done(500);
        frame_check(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/solver_dispatch.md
Name: solver_dispatch

Overview:
Dynamic row scheduler between NUM_SOLVERS external pattern solvers and a single shared frame-buffer write port. Replaces static per-solver interleaving with on-demand row assignment, so faster solvers take more rows. Collects pixel results through round-robin arbitration into linear frame addresses. Measures total solve time.

Parameters:
NUM_SOLVERS, 4, number of solver channels (1..32)
NUM_COLUMNS, 640, pixels per row
NUM_ROWS, 480, rows per frame
COORD_W, 27, signed fixed-point coordinate width
PIX_W, 4, pixel result width
ROW_W, 10, row index width; must satisfy NUM_ROWS <= 2^ROW_W
ADDR_W, 19, frame address width; must satisfy NUM_ROWS*NUM_COLUMNS <= 2^ADDR_W

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame
min_y  in  COORD_W  signed y of row 0; latched on accepted start
dy  in  COORD_W  signed row step; latched on accepted start
job_valid  out  NUM_SOLVERS  one-hot row offer to a channel
job_ready  in  NUM_SOLVERS  channel can accept a row
job_row  out  ROW_W  row index of the offered job
job_y  out  COORD_W  y coordinate of the offered row
res_valid  in  NUM_SOLVERS  channel presents one pixel
res_ready  out  NUM_SOLVERS  one-hot grant; a pixel transfers when valid and ready are both high
res_data  in  NUM_SOLVERS*PIX_W  per-channel pixel; channel i uses bits [i*PIX_W +: PIX_W]
fb_wr_en  out  1  frame-buffer write strobe
fb_wr_addr  out  ADDR_W  row*NUM_COLUMNS + column
fb_wr_data  out  PIX_W  pixel value
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
solve_time  out  32  cycles spent in RUN and DRAIN
proto_err  out  1  sticky flag; set when res_valid is asserted by an idle channel

Behaviour:
- Reset values: state=IDLE; all outputs 0; all channels idle; counters 0. Reset applies on any cycle, including mid-frame, and discards all work.
- States:
  - IDLE: start -> RUN. On the transition, latch min_y and dy; next_row=0, next_y=min_y, next_base=0; clear solve_time and proto_err.
  - RUN: dispatch rows. When next_row reaches NUM_ROWS -> DRAIN.
  - DRAIN: no new jobs. When all channels are idle and the write register is empty -> DONE.
  - DONE: holds done=1. start -> RUN with the same relaunch actions as from IDLE.
  - start is ignored in RUN and DRAIN.
- Dispatch (RUN only):
  - Choose the first channel that is idle and has job_ready high, in round-robin order starting after the last channel dispatched.
  - Drive job_valid one-hot to that channel, with job_row=next_row and job_y=next_y.
  - At most one transfer per cycle. The transfer occurs when job_valid[i] and job_ready[i] are both high.
  - On transfer: channel i becomes busy, base[i]=next_base, col[i]=0; next_row+=1, next_y+=dy (wraps at COORD_W), next_base+=NUM_COLUMNS.
  - If job_ready[i] drops before transfer, the offer is withdrawn and re-arbitrated on the next cycle with the same row.
- Results:
  - Grant is round-robin among busy channels with res_valid high. At most one grant per cycle. The grant is combinational from res_valid and the registered state.
  - On a granted transfer, the following cycle drives fb_wr_en=1, fb_wr_addr=base[i]+col[i], fb_wr_data=res_data[i] (1-cycle latency, registered). col[i] then increments.
  - When col[i]==NUM_COLUMNS-1 is transferred, channel i returns to idle. It is eligible for a new job no earlier than the next cycle.
  - res_valid from an idle channel is never granted and sets proto_err.
- solve_time: increments each cycle in RUN and DRAIN, saturates at 0xFFFFFFFF, and holds in IDLE and DONE.
- NUM_SOLVERS=1: round-robin degenerates to fixed selection, with identical behaviour otherwise.

Optional Feature:
SOLVER_STATS_EN
- When defined:
  - Adds input stat_sel [4:0] and outputs stat_rows [ROW_W-1:0] and stat_stall [31:0].
  - stat_rows is the number of rows completed by channel stat_sel in the current frame.
  - stat_stall counts cycles in which at least one busy channel has res_valid high but is not granted. It saturates.
  - Both statistics clear on an accepted start.
- When undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset with NUM_SOLVERS=4, 8x4 frame -> all outputs 0, state IDLE; start with min_y=-100, dy=5 -> job_y sequence -100,-95,-90,-85 on rows 0..3.
- All job_ready and res_valid held high, 8x4 frame -> addresses 0..31 each written exactly once; done=1; solve_time equals the measured RUN+DRAIN cycle count; proto_err=0.
- job_ready high only on channel 2 -> all 4 rows go to channel 2; writes are sequential 0..31; stat_rows(2)=4 when SOLVER_STATS_EN is defined.
- All four busy channels assert res_valid continuously -> grants rotate 0,1,2,3,0,...; stat_stall increments every cycle.
- res_valid on an idle channel -> no grant, proto_err=1 and sticky; a mid-RUN start pulse is ignored.
- Reset asserted mid-DRAIN -> next cycle state IDLE, busy=0, fb_wr_en=0; a new start completes a clean full frame.
